rate_counter_array: RTL and testbench
=====================================

Name: rate_counter_array

Overview:
- NUM_CHANNELS independent display counters. Each channel is advanced by its own programmable rate divider.
- Single clock throughout. Counter advance uses a one-cycle Tick qualifier, never a derived or gated clock.
- Per channel: up/down direction, wrap/saturate mode, synchronous load, pause, and restart.
- Drives hex/LED display logic at board level; sits between switch/key inputs and the display decoders.

Parameters:
- CLOCK_FREQUENCY, 500, ClockIn cycles per base tick period (Speed=1).
- NUM_CHANNELS, 2, number of independent counter channels.
- COUNT_WIDTH, 4, bits per channel counter value.
- SPEED_WIDTH, 2, bits per channel speed code.

Ports:
- ClockIn  input  1  system clock.
- Resetn  input  1  asynchronous, active-low reset.
- Enable  input  NUM_CHANNELS  per-channel run; low = pause (divider and counter frozen).
- Restart  input  NUM_CHANNELS  synchronous pulse: re-arm divider with current Speed.
- Speed  input  NUM_CHANNELS*SPEED_WIDTH  per-channel speed code; channel i at [i*SPEED_WIDTH +: SPEED_WIDTH].
- Down  input  NUM_CHANNELS  1 = count down, 0 = count up.
- Saturate  input  NUM_CHANNELS  1 = hold at terminal, 0 = wrap.
- Load  input  NUM_CHANNELS  synchronous load strobe.
- LoadValue  input  NUM_CHANNELS*COUNT_WIDTH  load data, packed like Speed.
- CounterValue  output  NUM_CHANNELS*COUNT_WIDTH  per-channel count.
- Tick  output  NUM_CHANNELS  one-cycle advance qualifier.
- Terminal  output  NUM_CHANNELS  level: count at terminal value for current direction.

Behaviour:
- Reset (Resetn low, asynchronous):
  - CounterValue=0 and divider=0 for all channels.
  - armed=0 for all channels.
  - Tick=0.
  - Terminal reflects the reset count, so Terminal=1 for channels with Down=1.
- Period from speed code k:
  - k=0 gives period 1 (tick every cycle).
  - k>0 gives period CLOCK_FREQUENCY << (k-1).
  - Divider width is sized for the maximum code 2**SPEED_WIDTH-1; no truncation is allowed.
- Divider, per channel, one state variable `armed`. Each bullet applies only on an Enable=1 cycle:
  - armed=0: load cycle. Divider <= period-1, armed <= 1, no Tick.
  - armed=1, divider>0: divider decrements.
  - armed=1, divider==0: Tick=1 (combinational from registered state and Enable); divider reloads period-1 from Speed sampled this cycle.
- Enable=0: divider, armed and counter all hold; Tick=0.
- Speed changes take effect only at reload (divider==0) or on Restart. A mid-period change never shortens or stretches the current period.
- Restart=1: armed <= 0, Tick suppressed that cycle. The next enabled cycle is a load cycle. Restart acts regardless of Enable.
- First Tick after reset or Restart comes period+1 enabled cycles after the load-capable edge. Speed 0 therefore ticks on every cycle after the load cycle.
- Counter update priority per channel: Load > Tick advance > hold.
  - Load sets the count to LoadValue whatever Enable is, and does not disturb the divider.
  - Load coincident with Tick: Load wins and the advance is discarded.
- Advance, up direction: MAX = 2**COUNT_WIDTH-1.
  - Wrap mode: MAX -> 0.
  - Saturate mode: holds at MAX.
- Advance, down direction: 0 -> MAX when wrapping; holds at 0 when saturating.
- Tick still pulses while saturated. The count holds.
- Terminal = (Down ? count==0 : count==MAX). It is combinational from the current count and Down.
- Flipping Down takes effect on the next Tick, with no extra latency.
- Channels are fully independent; no shared state between channels.

Decomposition:
- Package rate_counter_pkg:
  - localparams MAX_SPEED_CODE and DIV_WIDTH.
  - function speed_period(code) returning a DIV_WIDTH-bit value.
  - typedef div_t for the divider register.
- Sub-module rate_tick_gen: one divider (Enable, Restart, Speed -> Tick). Instantiate it NUM_CHANNELS times via generate.
- Counter/mode logic stays in the top, also under generate.

Test Plan (CLOCK_FREQUENCY=4, NUM_CHANNELS=2, COUNT_WIDTH=4):
- Reset, then ch0 Speed=1, up, wrap, Enable=1 -> ch0 Ticks on enabled cycles 5, 9, 13, ...; after 16 Ticks the count goes 15 -> 0.
- ch1 Speed=3, Down=1, Saturate=1, Load=1 with LoadValue=2 -> Ticks every 16 cycles; count 2, 1, 0, then holds 0; Terminal=1; Tick keeps pulsing.
- ch0 Speed changed 1 -> 2 mid-period -> current 4-cycle period completes, then the next period is 8 cycles; Restart mid-period gives a load cycle, then the first Tick 9 cycles later.
- Enable deasserted for 7 cycles mid-period -> divider and count frozen; the Tick phase shifts by exactly 7 cycles; ch1 unaffected.
- Load asserted on the same cycle as a ch0 Tick with LoadValue=9 -> count=9 (no 10); divider phase unchanged.
- Resetn dropped asynchronously mid-count -> all outputs clear immediately without a clock edge; after release, ch0 Speed=0 shows a load cycle, then Tick every cycle.

Source files
------------

// File: rtl/rate_counter_pkg.sv
// -----------------------------------------------------------------------------
// rate_counter_pkg
//
// Shared definitions for the rate counter array:
//   - default build parameters (base tick period, speed code width)
//   - MAX_SPEED_CODE / DIV_WIDTH for the default build and the div_t type
//   - div_width(): divider width needed for any (clock frequency, speed width)
//     pair, so that the slowest speed code never truncates
//   - speed_period(): period in clock cycles selected by a speed code
// -----------------------------------------------------------------------------
package rate_counter_pkg;

    localparam int unsigned DEF_CLOCK_FREQUENCY = 500;
    localparam int unsigned DEF_SPEED_WIDTH     = 2;
    localparam int unsigned MAX_SPEED_CODE      = (32'd1 << DEF_SPEED_WIDTH) - 32'd1;

    // Period in clock cycles for a speed code: code 0 ticks every cycle,
    // code k>0 gives clk_freq doubled (k-1) times.
    function automatic logic [63:0] speed_period(input int unsigned code,
                                                 input int unsigned clk_freq);
        logic [63:0] period;
        if (code == 32'd0) begin
            period = 64'd1;
        end else begin
            period = 64'(clk_freq) << (code - 32'd1);
        end
        return period;
    endfunction

    // Smallest width w with 2**w >= longest period, so period-1 always fits.
    function automatic int unsigned div_width(input int unsigned clk_freq,
                                              input int unsigned speed_width);
        int unsigned max_code;
        logic [63:0] max_period;
        int unsigned w;
        max_code   = (32'd1 << speed_width) - 32'd1;
        max_period = speed_period(max_code, clk_freq);
        w          = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd64; i++) begin
            if ((64'd1 << i) < max_period) begin
                w = i + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    localparam int unsigned DIV_WIDTH = div_width(DEF_CLOCK_FREQUENCY, DEF_SPEED_WIDTH);

    typedef logic [DIV_WIDTH-1:0] div_t;

endpackage : rate_counter_pkg

// File: rtl/rate_counter_array_if.sv
// -----------------------------------------------------------------------------
// rate_counter_array_if
//
// Control/status bundle of the rate counter array. All vectors carry one bit
// (or one packed field) per channel; channel i of a packed field sits at
// [i*WIDTH +: WIDTH].
//   master : drives Enable/Restart/Speed/Down/Saturate/Load/LoadValue,
//            observes CounterValue/Tick/Terminal (switch/key side)
//   slave  : the counter array itself
// -----------------------------------------------------------------------------
interface rate_counter_array_if #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned COUNT_WIDTH  = 4,
    parameter int unsigned SPEED_WIDTH  = 2
);

    logic [NUM_CHANNELS-1:0]             Enable;
    logic [NUM_CHANNELS-1:0]             Restart;
    logic [NUM_CHANNELS*SPEED_WIDTH-1:0] Speed;
    logic [NUM_CHANNELS-1:0]             Down;
    logic [NUM_CHANNELS-1:0]             Saturate;
    logic [NUM_CHANNELS-1:0]             Load;
    logic [NUM_CHANNELS*COUNT_WIDTH-1:0] LoadValue;
    logic [NUM_CHANNELS*COUNT_WIDTH-1:0] CounterValue;
    logic [NUM_CHANNELS-1:0]             Tick;
    logic [NUM_CHANNELS-1:0]             Terminal;

    modport master (
        output Enable, Restart, Speed, Down, Saturate, Load, LoadValue,
        input  CounterValue, Tick, Terminal
    );

    modport slave (
        input  Enable, Restart, Speed, Down, Saturate, Load, LoadValue,
        output CounterValue, Tick, Terminal
    );

endinterface : rate_counter_array_if

// File: rtl/rate_counter_array_tick_gen.sv
// -----------------------------------------------------------------------------
// rate_tick_gen
//
// One programmable rate divider producing a one-cycle Tick qualifier.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset (divider=0, disarmed)
//   enable_i  : run; low freezes the divider and suppresses the tick
//   restart_i : disarm; the next enabled cycle reloads from speed_i
//   speed_i   : speed code, sampled only on load cycles and at reload
//   tick_o    : combinational from registered state, enable and restart
//
// A disarmed divider spends one enabled cycle loading period-1, then counts
// down to zero; the cycle it sits at zero is the tick cycle, which reloads
// from the speed code present on that cycle. A speed change therefore never
// alters a period already in progress.
// -----------------------------------------------------------------------------
module rate_tick_gen
    import rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = DEF_CLOCK_FREQUENCY,
    parameter int unsigned SPEED_WIDTH     = DEF_SPEED_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   restart_i,
    input  logic [SPEED_WIDTH-1:0] speed_i,
    output logic                   tick_o
);

    localparam int unsigned DIV_W = div_width(CLOCK_FREQUENCY, SPEED_WIDTH);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] reload_s;
    logic             armed_q;
    logic             armed_d;
    logic             tick_s;

    // Reload value (period-1) selected by the speed code on this cycle.
    always_comb begin
        reload_s = DIV_W'(speed_period(32'(speed_i), CLOCK_FREQUENCY) - 64'd1);
    end

    // Divider next state and tick decode; restart overrides enable.
    always_comb begin
        div_d   = div_q;
        armed_d = armed_q;
        tick_s  = 1'b0;
        if (restart_i) begin
            armed_d = 1'b0;
        end else if (enable_i) begin
            if (!armed_q) begin
                div_d   = reload_s;
                armed_d = 1'b1;
            end else if (div_q != {DIV_W{1'b0}}) begin
                div_d = div_q - DIV_W'(1);
            end else begin
                tick_s = 1'b1;
                div_d  = reload_s;
            end
        end else begin
            div_d   = div_q;
            armed_d = armed_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= {DIV_W{1'b0}};
            armed_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            armed_q <= armed_d;
        end
    end

    assign tick_o = tick_s;

endmodule : rate_tick_gen

// File: rtl/rate_counter_array.sv
// -----------------------------------------------------------------------------
// rate_counter_array
//
// NUM_CHANNELS independent display counters, each advanced by its own
// rate_tick_gen. Everything runs on ClockIn; Tick is a qualifier, never a
// clock.
//   ClockIn : system clock
//   Resetn  : asynchronous active-low reset (counts and dividers cleared)
//   bus     : rate_counter_array_if slave port
//             Enable/Restart/Speed     -> per-channel divider control
//             Down/Saturate            -> direction and wrap/saturate mode
//             Load/LoadValue           -> synchronous load, wins over Tick
//             CounterValue/Tick/Terminal <- per-channel status
//
// Terminal is combinational from the count and the current Down input, so
// it follows a direction flip immediately and reads 1 in reset for Down=1.
// -----------------------------------------------------------------------------
module rate_counter_array
    import rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = DEF_CLOCK_FREQUENCY,
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned COUNT_WIDTH     = 4,
    parameter int unsigned SPEED_WIDTH     = DEF_SPEED_WIDTH
) (
    input  logic                 ClockIn,
    input  logic                 Resetn,
    rate_counter_array_if.slave  bus
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = {COUNT_WIDTH{1'b0}};

    logic [NUM_CHANNELS-1:0]                  tick_s;
    logic [NUM_CHANNELS-1:0]                  terminal_s;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] count_all_s;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch

        logic [COUNT_WIDTH-1:0] count_q;
        logic [COUNT_WIDTH-1:0] count_d;

        rate_tick_gen #(
            .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
            .SPEED_WIDTH     (SPEED_WIDTH)
        ) u_tick_gen (
            .clk_i     (ClockIn),
            .rst_ni    (Resetn),
            .enable_i  (bus.Enable[ch]),
            .restart_i (bus.Restart[ch]),
            .speed_i   (bus.Speed[ch*SPEED_WIDTH +: SPEED_WIDTH]),
            .tick_o    (tick_s[ch])
        );

        // Count next state: load beats advance; saturated channels still tick
        // but hold their terminal value.
        always_comb begin
            count_d = count_q;
            if (bus.Load[ch]) begin
                count_d = bus.LoadValue[ch*COUNT_WIDTH +: COUNT_WIDTH];
            end else if (tick_s[ch]) begin
                if (bus.Down[ch]) begin
                    if (count_q == MIN_COUNT) begin
                        count_d = bus.Saturate[ch] ? MIN_COUNT : MAX_COUNT;
                    end else begin
                        count_d = count_q - COUNT_WIDTH'(1);
                    end
                end else begin
                    if (count_q == MAX_COUNT) begin
                        count_d = bus.Saturate[ch] ? MAX_COUNT : MIN_COUNT;
                    end else begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
            end else begin
                count_d = count_q;
            end
        end

        // Channel count register.
        always_ff @(posedge ClockIn or negedge Resetn) begin
            if (!Resetn) begin
                count_q <= MIN_COUNT;
            end else begin
                count_q <= count_d;
            end
        end

        assign count_all_s[ch] = count_q;
        assign terminal_s[ch]  = bus.Down[ch] ? (count_q == MIN_COUNT)
                                              : (count_q == MAX_COUNT);
    end

    assign bus.CounterValue = count_all_s;
    assign bus.Tick         = tick_s;
    assign bus.Terminal     = terminal_s;

endmodule : rate_counter_array

// File: tb/tb_rate_counter_array.sv
// -----------------------------------------------------------------------------
// tb_rate_counter_array
//
// Directed scenarios with hand-computed expectations, followed by a randomized
// run. A behavioural model (per channel: count as an integer, whether the
// divider is armed, and enabled cycles still to wait before the next tick) is
// compared against Tick, CounterValue and Terminal on every falling edge.
// -----------------------------------------------------------------------------
module tb_rate_counter_array;

    localparam int unsigned CF   = 4;
    localparam int unsigned NCH  = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned SW   = 2;
    localparam int          MAXV = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rate_counter_array_if #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .SPEED_WIDTH(SW)) bus ();

    rate_counter_array #(
        .CLOCK_FREQUENCY (CF),
        .NUM_CHANNELS    (NCH),
        .COUNT_WIDTH     (CW),
        .SPEED_WIDTH     (SW)
    ) dut (
        .ClockIn (clk),
        .Resetn  (rst_n),
        .bus     (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int period_of(input int code);
        return (code == 0) ? 1 : (CF << (code - 1));
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_count [NCH];
    bit m_armed [NCH];
    int m_wait  [NCH];

    always @(negedge clk) begin : compare
        logic [NCH-1:0]    e_tick;
        logic [NCH-1:0]    e_term;
        logic [NCH*CW-1:0] e_val;
        int                spd;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_count[c] = 0;
                m_armed[c] = 1'b0;
                m_wait[c]  = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e_tick[c] = rst_n && bus.Enable[c] && !bus.Restart[c] && m_armed[c] && (m_wait[c] == 0);
            e_val[c*CW +: CW] = CW'(m_count[c]);
            e_term[c] = bus.Down[c] ? (m_count[c] == 0) : (m_count[c] == MAXV);
        end
        check("cyc_tick", 32'(bus.Tick), 32'(e_tick));
        check("cyc_value", 32'(bus.CounterValue), 32'(e_val));
        check("cyc_terminal", 32'(bus.Terminal), 32'(e_term));
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                spd = int'(bus.Speed[c*SW +: SW]);
                if (bus.Restart[c]) begin
                    m_armed[c] = 1'b0;
                end else if (bus.Enable[c]) begin
                    if (!m_armed[c]) begin
                        m_armed[c] = 1'b1;
                        m_wait[c]  = period_of(spd) - 1;
                    end else if (m_wait[c] > 0) begin
                        m_wait[c] = m_wait[c] - 1;
                    end else begin
                        m_wait[c] = period_of(spd) - 1;
                    end
                end
                if (bus.Load[c]) begin
                    m_count[c] = int'(bus.LoadValue[c*CW +: CW]);
                end else if (e_tick[c]) begin
                    if (bus.Down[c]) begin
                        if (bus.Saturate[c]) m_count[c] = (m_count[c] > 0) ? m_count[c] - 1 : 0;
                        else                 m_count[c] = (m_count[c] + MAXV) % (MAXV + 1);
                    end else begin
                        if (bus.Saturate[c]) m_count[c] = (m_count[c] < MAXV) ? m_count[c] + 1 : MAXV;
                        else                 m_count[c] = (m_count[c] + 1) % (MAXV + 1);
                    end
                end
            end
        end
    end

    // ---------------- tick timestamp monitor ----------------
    int cyc = 0;
    int q0[$];
    int q1[$];
    int v0[$];

    always @(negedge clk) begin : monitor
        cyc++;
        if (bus.Tick[0]) begin
            q0.push_back(cyc);
            v0.push_back(int'(bus.CounterValue[CW-1:0]));
        end
        if (bus.Tick[1]) q1.push_back(cyc);
    end

    int cyc_base = 0;
    int b0 = 0;
    int b1 = 0;

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        cyc_base = cyc;
        b0 = q0.size();
        b1 = q1.size();
    endtask

    function automatic int t0(input int k);
        return (b0 + k < q0.size()) ? q0[b0 + k] - cyc_base : -1;
    endfunction

    function automatic int t1(input int k);
        return (b1 + k < q1.size()) ? q1[b1 + k] - cyc_base : -1;
    endfunction

    function automatic int val0(input int k);
        return (b0 + k < v0.size()) ? v0[b0 + k] : -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int c_before;
        bus.Enable    = 2'b00;
        bus.Restart   = 2'b00;
        bus.Speed     = 4'h0;
        bus.Down      = 2'b10;
        bus.Saturate  = 2'b00;
        bus.Load      = 2'b00;
        bus.LoadValue = 8'h00;
        rst_n         = 1'b0;
        run(3);
        check("reset_value", 32'(bus.CounterValue), 32'd0);
        check("reset_tick", 32'(bus.Tick), 32'd0);
        check("reset_terminal", 32'(bus.Terminal), 32'd2);

        // ch0 speed 1 up/wrap, ch1 speed 3 down/saturate loaded with 2
        bus.Enable    = 2'b11;
        bus.Speed     = {2'd3, 2'd1};
        bus.Saturate  = 2'b10;
        bus.Load      = 2'b10;
        bus.LoadValue = {4'd2, 4'd0};
        rst_n         = 1'b1;
        mark();
        run(1);
        bus.Load = 2'b00;
        run(69);
        check("ch0_tick1", 32'(t0(0)), 32'd5);
        check("ch0_tick2", 32'(t0(1)), 32'd9);
        check("ch0_tick3", 32'(t0(2)), 32'd13);
        check("ch0_tick_count", 32'(q0.size() - b0), 32'd17);
        check("ch0_at_tick16", 32'(val0(15)), 32'd15);
        check("ch0_wrapped", 32'(val0(16)), 32'd0);
        check("ch0_value", 32'(bus.CounterValue[3:0]), 32'd1);
        check("ch1_tick1", 32'(t1(0)), 32'd17);
        check("ch1_tick2", 32'(t1(1)), 32'd33);
        check("ch1_tick_count", 32'(q1.size() - b1), 32'd4);
        check("ch1_value", 32'(bus.CounterValue[7:4]), 32'd0);
        check("ch1_terminal", 32'(bus.Terminal[1]), 32'd1);

        // ch0 speed 1 -> 2 mid-period
        bus.Speed = {2'd3, 2'd2};
        mark();
        run(12);
        check("spd_chg_tick1", 32'(t0(0)), 32'd3);
        check("spd_chg_tick2", 32'(t0(1)), 32'd11);

        // restart mid-period
        bus.Restart = 2'b01;
        mark();
        run(1);
        bus.Restart = 2'b00;
        run(11);
        check("restart_tick", 32'(t0(0)), 32'd10);
        check("restart_count", 32'(q0.size() - b0), 32'd1);

        // pause ch0 for 7 cycles
        mark();
        c_before   = int'(bus.CounterValue[3:0]);
        bus.Enable = 2'b10;
        run(7);
        check("pause_hold", 32'(bus.CounterValue[3:0]), 32'(c_before));
        check("pause_no_tick", 32'(q0.size() - b0), 32'd0);
        bus.Enable = 2'b11;
        run(10);
        check("pause_shift", 32'(t0(0)), 32'd13);

        // load on a tick cycle
        run(3);
        bus.Load      = 2'b01;
        bus.LoadValue = {4'd0, 4'd9};
        run(1);
        bus.Load = 2'b00;
        check("load_tick_phase", 32'(t0(1)), 32'd21);
        check("load_wins", 32'(bus.CounterValue[3:0]), 32'd9);
        run(9);
        check("load_next_tick", 32'(t0(2)), 32'd29);
        check("load_then_adv", 32'(bus.CounterValue[3:0]), 32'd10);

        // asynchronous reset mid-count
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_value", 32'(bus.CounterValue), 32'd0);
        check("async_tick", 32'(bus.Tick), 32'd0);
        check("async_terminal", 32'(bus.Terminal), 32'd2);
        @(posedge clk);
        #1;
        bus.Speed = {2'd3, 2'd0};
        rst_n     = 1'b1;
        mark();
        run(6);
        check("spd0_first_tick", 32'(t0(0)), 32'd2);
        check("spd0_tick_count", 32'(q0.size() - b0), 32'd5);
        check("spd0_value", 32'(bus.CounterValue[3:0]), 32'd5);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                bus.Enable[c]  = ($urandom_range(7) != 0);
                bus.Restart[c] = ($urandom_range(39) == 0);
                bus.Load[c]    = ($urandom_range(24) == 0);
                bus.LoadValue[c*CW +: CW] = CW'($urandom_range(MAXV));
                if ($urandom_range(29) == 0) bus.Speed[c*SW +: SW] = SW'($urandom_range(3));
                if ($urandom_range(49) == 0) bus.Down[c] = ~bus.Down[c];
                if ($urandom_range(49) == 0) bus.Saturate[c] = ~bus.Saturate[c];
            end
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rate_counter_array
